// File: rtl/bs_link_pkg.sv
// Shared types and default sizing for the bit-serial link receiver.
package bs_link_pkg;

    localparam int LINK_WIDTH    = 16;
    localparam int LINK_BIT_CLKS = 100;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        CHECK,
        WAIT_LOW
    } link_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input line.
module sync2 (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bs_link_rx.sv
// Bit-serial link receiver: framed by recSig, WIDTH data slots LSB first plus
// one even-parity slot, each BIT_CLKS cycles long, sampled at mid-slot.
module bs_link_rx
    import bs_link_pkg::*;
#(
    parameter int WIDTH    = LINK_WIDTH,
    parameter int BIT_CLKS = LINK_BIT_CLKS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             bsIn,
    input  logic             recSig,
    output logic [WIDTH-1:0] data,
    output logic             dataValid,
    output logic             frameErr,
    output logic             busy
);

    localparam int CW = $clog2(BIT_CLKS);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CLKS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    logic             sig_s;
    logic             bs_s;
    logic             sig_prev;
    logic [1:0]       warm;
    logic             sig_rise;
    link_state_t      state;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_bit;

    sync2 u_sync_sig (.clk(clk), .clr(clr), .d(recSig), .q(sig_s));
    sync2 u_sync_bs  (.clk(clk), .clr(clr), .d(bsIn),   .q(bs_s));

    // The synchronizers read 0 for two cycles after clr even if recSig is
    // already high, so the edge detector holds "previous" at 1 until they settle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            warm     <= 2'b00;
            sig_prev <= 1'b1;
        end else begin
            warm     <= {warm[0], 1'b1};
            sig_prev <= warm[1] ? sig_s : 1'b1;
        end
    end

    assign sig_rise = sig_s & ~sig_prev;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            data      <= '0;
            dataValid <= 1'b0;
            frameErr  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dataValid <= 1'b0;
            frameErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sig_rise) begin
                        state   <= DATA;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                DATA: begin
                    if (!sig_s) begin
                        state    <= IDLE;
                        frameErr <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        if (cyc_cnt == HALF_CNT) begin
                            for (int i = 0; i < WIDTH; i++) begin
                                if (bit_cnt == BW'(i)) shreg[i] <= bs_s;
                            end
                        end
                        if (cyc_cnt == LAST_CNT) begin
                            cyc_cnt <= '0;
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == LAST_BIT) state <= PARITY;
                        end else begin
                            cyc_cnt <= cyc_cnt + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (!sig_s) begin
                        state    <= IDLE;
                        frameErr <= 1'b1;
                        busy     <= 1'b0;
                    end else if (cyc_cnt == HALF_CNT) begin
                        par_bit <= bs_s;
                        state   <= CHECK;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                CHECK: begin
                    if (^{shreg, par_bit}) begin
                        frameErr <= 1'b1;
                    end else begin
                        data      <= shreg;
                        dataValid <= 1'b1;
                    end
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!sig_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bs_link_rx.sv
// Scoreboard bench for bs_link_rx: directed frames push expected pulses,
// a negedge monitor pops and compares whenever dataValid or frameErr fires.
module tb_bs_link_rx;

    localparam int WIDTH    = 16;
    localparam int BIT_CLKS = 8;

    typedef struct {
        logic        is_err;
        logic [15:0] val;
    } exp_t;

    logic        clk;
    logic        clr;
    logic        bsIn;
    logic        recSig;
    logic [15:0] data;
    logic        dataValid;
    logic        frameErr;
    logic        busy;

    exp_t        exp_q[$];
    logic [15:0] held;
    logic        prev_pulse;
    int          total_cnt;
    int          bad_cnt;

    bs_link_rx #(.WIDTH(WIDTH), .BIT_CLKS(BIT_CLKS)) dut (
        .clk(clk),
        .clr(clr),
        .bsIn(bsIn),
        .recSig(recSig),
        .data(data),
        .dataValid(dataValid),
        .frameErr(frameErr),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Sends one frame; abort_bit drops recSig mid-slot, clr_bit pulses clr mid-slot.
    task automatic applyStimulus(input logic [15:0] val, input logic par,
                                 input int abort_bit, input int clr_bit, input int hold_cycles);
        exp_t e;
        if (abort_bit >= 0) begin
            e.is_err = 1'b1;
            e.val    = held;
            exp_q.push_back(e);
        end else if (clr_bit >= 0) begin
            held = 16'h0000;
        end else if ((^val) == par) begin
            e.is_err = 1'b0;
            e.val    = val;
            held     = val;
            exp_q.push_back(e);
        end else begin
            e.is_err = 1'b1;
            e.val    = held;
            exp_q.push_back(e);
        end

        repeat (2) @(posedge clk);
        #1;
        recSig = 1'b1;
        for (int k = 0; k <= WIDTH; k++) begin
            bsIn = (k < WIDTH) ? val[k] : par;
            for (int c = 0; c < BIT_CLKS; c++) begin
                if (k == abort_bit && c == BIT_CLKS / 2) begin
                    checkOutput("busy_mid_frame", {31'd0, busy}, 32'd1);
                    recSig = 1'b0;
                    bsIn   = 1'b0;
                    return;
                end
                if (k == clr_bit && c == BIT_CLKS / 2) begin
                    checkOutput("busy_pre_clr", {31'd0, busy}, 32'd1);
                    #2 clr = 1'b1;
                    #1;
                    checkOutput("clr_data",  {16'd0, data}, 32'd0);
                    checkOutput("clr_valid", {31'd0, dataValid}, 32'd0);
                    checkOutput("clr_err",   {31'd0, frameErr}, 32'd0);
                    checkOutput("clr_busy",  {31'd0, busy}, 32'd0);
                    #2 clr = 1'b0;
                end
                @(posedge clk);
                #1;
            end
        end
        for (int h = 0; h < hold_cycles; h++) begin
            if (h % 50 == 25) checkOutput("busy_hold", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        recSig = 1'b0;
        bsIn   = 1'b0;
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (!clr && (dataValid || frameErr)) begin
            total_cnt++;
            if (prev_pulse) begin
                bad_cnt++;
                $display("[TB] FAIL pulse_spacing: got back-to-back pulses expected at least one idle cycle");
            end
            if (exp_q.size() == 0) begin
                total_cnt++;
                bad_cnt++;
                $display("[TB] FAIL unexpected_pulse: got valid=%b err=%b data=%h expected no pulse",
                         dataValid, frameErr, data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pulse_event", {14'd0, dataValid, frameErr, data},
                            {14'd0, ~e.is_err, e.is_err, e.val});
            end
        end
        prev_pulse = !clr && (dataValid || frameErr);
    end

    initial begin
        total_cnt  = 0;
        bad_cnt    = 0;
        prev_pulse = 1'b0;
        held       = 16'h0000;
        clr        = 1'b1;
        bsIn       = 1'b0;
        recSig     = 1'b0;
        #2;
        checkOutput("reset_data",  {16'd0, data}, 32'd0);
        checkOutput("reset_valid", {31'd0, dataValid}, 32'd0);
        checkOutput("reset_err",   {31'd0, frameErr}, 32'd0);
        checkOutput("reset_busy",  {31'd0, busy}, 32'd0);
        #20 clr = 1'b0;
        repeat (5) @(posedge clk);

        applyStimulus(16'hA5C3, 1'b0, -1, -1, 0);
        repeat (8) @(posedge clk);
        applyStimulus(16'h0001, 1'b0, -1, -1, 0);
        repeat (8) @(posedge clk);
        applyStimulus(16'hFFFF, 1'b0, 7, -1, 0);
        repeat (6) @(posedge clk);
        #1 checkOutput("busy_after_abort", {31'd0, busy}, 32'd0);
        applyStimulus(16'h1234, 1'b1, -1, -1, 300);
        repeat (6) @(posedge clk);
        #1 checkOutput("busy_after_hold", {31'd0, busy}, 32'd0);
        applyStimulus(16'h5555, 1'b0, -1, 10, 0);
        repeat (8) @(posedge clk);
        applyStimulus(16'h00FF, 1'b0, -1, -1, 0);
        repeat (8) @(posedge clk);
        applyStimulus(16'h8001, 1'b0, -1, -1, 0);
        applyStimulus(16'h7FFE, 1'b0, -1, -1, 0);

        repeat (20) @(posedge clk);
        #1;
        checkOutput("pending_events", exp_q.size(), 32'd0);
        checkOutput("data_final", {16'd0, data}, {16'd0, held});
        checkOutput("busy_final", {31'd0, busy}, 32'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/bs_link_rx.md
BS_LINK_RX -- requirements
Module: bs_link_rx

Interface
REQ-001 Parameter WIDTH, default 16: payload bits per frame.
REQ-002 Parameter BIT_CLKS, default 100: clk cycles per bit slot; SHALL be >= 4 and even.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 clr  input  1  asynchronous, active-high reset.
REQ-006 bsIn  input  1  serial payload line from the master; asynchronous to clk.
REQ-007 recSig  input  1  frame-envelope line from the master, high for the whole frame; asynchronous to clk.
REQ-008 data  output  WIDTH  last good payload, held until the next good frame.
REQ-009 dataValid  output  1  one-cycle pulse when data updates.
REQ-010 frameErr  output  1  one-cycle pulse on a parity failure or an aborted frame.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 bsIn and recSig SHALL each pass a 2-flop synchronizer; all logic below uses the synchronized versions (sig_s, bs_s).
- Frame format: recSig rises, then WIDTH data slots LSB first, then one even-parity slot; each slot is BIT_CLKS cycles.
- Slot k starts at the cycle in which the rising edge of sig_s is detected.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, CHECK and WAIT_LOW.
REQ-014 IDLE -> DATA on a sig_s rising edge (sig_s=1, previous sig_s=0); bit counter and cycle counter clear to 0.
REQ-015 Sampling in DATA: when the cycle counter = BIT_CLKS/2-1, bs_s SHALL be shifted into shift-register bit [bit counter].
- When the cycle counter = BIT_CLKS-1, the cycle counter wraps to 0 and the bit counter increments.
- After bit WIDTH-1 wraps, the FSM goes to PARITY.
REQ-016 PARITY SHALL sample bs_s at BIT_CLKS/2-1 into a parity register, then go to CHECK on the next cycle.
REQ-017 CHECK lasts one cycle; XOR of the shift register and the parity bit is computed.
- XOR = 0: data <= shift register, and dataValid pulses in the cycle after CHECK.
- XOR = 1: data is unchanged, and frameErr pulses in the cycle after CHECK.
- Both cases: CHECK -> WAIT_LOW.
REQ-018 WAIT_LOW -> IDLE when sig_s = 0.
- A frame whose recSig stays high SHALL NOT be re-received.
REQ-019 Abort: sig_s = 0 in any cycle of DATA or PARITY SHALL force IDLE and pulse frameErr in the next cycle; data is unchanged.
REQ-020 dataValid and frameErr SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-021 A sig_s rising edge seen in any state other than IDLE SHALL be ignored.
REQ-022 Counters SHALL be sized $clog2(BIT_CLKS) and $clog2(WIDTH+1) bits; no counter may wrap except as specified in REQ-015.

Reset
REQ-023 When clr is asserted:
- state = IDLE; counters, shift register, parity register and synchronizer flops = 0.
- data = 0, dataValid = 0, frameErr = 0, busy = 0.
- Effect is immediate, without waiting for clk.
REQ-024 clr asserted mid-frame SHALL discard the frame with no pulse.
- After clr deasserts, a recSig already high SHALL NOT start a frame; a fresh rising edge is required.

Structure
REQ-025 Package bs_link_pkg SHALL hold:
- the state enum type (link_state_t);
- the default constants LINK_WIDTH=16 and LINK_BIT_CLKS=100.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module, sync2 (ports clk, clr, d, q), instantiated twice.

Verification (WIDTH=16, BIT_CLKS=8)
REQ-027 Good frame 0xA5C3, parity 0 -> dataValid pulses once; data = 0xA5C3; frameErr stays 0.
REQ-028 Frame 0x0001 with parity 0 (wrong) -> frameErr pulses once; data keeps its previous value.
REQ-029 recSig dropped during bit 7 of frame 0xFFFF -> busy falls, frameErr pulses once, dataValid stays 0, data unchanged.
REQ-030 recSig held high for 300 cycles after a good 0x1234 -> exactly one dataValid; busy stays 1 until recSig falls.
REQ-031 clr pulsed during bit 10 -> all outputs 0 immediately; no pulse afterwards; the next clean frame 0x00FF is received correctly.
REQ-032 Two back-to-back frames 0x8001 then 0x7FFE, separated by 2 recSig-low cycles -> two dataValid pulses carrying those values in order.
